// File: rtl/alu.sv
// rtl/alu.sv - registered unsigned integer ALU with one-cycle latency
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_d, result_q;
  logic             div_zero_d, div_zero_q;
  logic             zero_q;
  logic             b_is_zero;

  assign b_is_zero = (b == '0);

  // Next result: purely combinational from a, b and op; divide/modulo by zero
  // return all ones / a and raise div_zero.
  always_comb begin
    result_d   = '0;
    div_zero_d = 1'b0;
    unique case (op_e'(op))
      OP_ADD: result_d = a + b;
      OP_SUB: result_d = a - b;
      OP_MUL: result_d = a * b;
      OP_DIV: begin
        if (b_is_zero) begin
          result_d   = '1;
          div_zero_d = 1'b1;
        end else begin
          result_d = a / b;
        end
      end
      OP_MOD: begin
        if (b_is_zero) begin
          result_d   = a;
          div_zero_d = 1'b1;
        end else begin
          result_d = a % b;
        end
      end
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_XOR: result_d = a ^ b;
      default: result_d = '0;
    endcase
  end

  // Output registers; zero is derived from result_d so it always matches result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      div_zero_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= (result_d == '0);
      div_zero_q <= div_zero_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: directed vectors plus random model check
module tb_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic [W-1:0] result;
  logic         zero, div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         z;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .zero     (zero),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic on 64-bit values, reduced modulo 2^32.
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [2:0] rop,
                           output logic [W-1:0] res, output logic dz);
    longint unsigned la, lb, m, r;
    la = 64'(ra);
    lb = 64'(rb);
    m  = 64'h1_0000_0000;
    dz = 1'b0;
    r  = 0;
    case (rop)
      3'd0: r = (la + lb) % m;
      3'd1: r = (la + m - lb) % m;
      3'd2: r = (la * lb) % m;
      3'd3: if (lb == 0) begin r = m - 1; dz = 1'b1; end else r = la / lb;
      3'd4: if (lb == 0) begin r = la;    dz = 1'b1; end else r = la % lb;
      3'd5: r = 64'(ra & rb);
      3'd6: r = 64'(ra | rb);
      default: r = 64'(ra ^ rb);
    endcase
    res = r[W-1:0];
  endtask

  task automatic check_out(input string name, input logic [W-1:0] er, input logic ez, input logic edz);
    checks++;
    if (result !== er || zero !== ez || div_zero !== edz) begin
      errors++;
      $display("FAIL %s: got result=%h zero=%b div_zero=%b, expected result=%h zero=%b div_zero=%b",
               name, result, zero, div_zero, er, ez, edz);
    end
  endtask

  task automatic drive_edge(input logic [W-1:0] da, input logic [W-1:0] db, input logic [2:0] dop,
                            input logic drst);
    a     = da;
    b     = db;
    op    = dop;
    rst_n = drst;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2:0] vop, input logic [W-1:0] vr, input logic vdz);
    vec_t v;
    v.name = n; v.a = va; v.b = vb; v.op = vop; v.res = vr; v.z = (vr == '0); v.dz = vdz;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] exp_r, prev_r;
    logic         exp_dz, prev_z, prev_dz;
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;

    add_vec("add_20_3",  32'd20, 32'd3, 3'b000, 32'd23, 1'b0);
    add_vec("sub_20_3",  32'd20, 32'd3, 3'b001, 32'd17, 1'b0);
    add_vec("mul_20_3",  32'd20, 32'd3, 3'b010, 32'd60, 1'b0);
    add_vec("div_20_3",  32'd20, 32'd3, 3'b011, 32'd6,  1'b0);
    add_vec("mod_20_3",  32'd20, 32'd3, 3'b100, 32'd2,  1'b0);
    add_vec("and_bits",  32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b101, 32'h00F0_000F, 1'b0);
    add_vec("or_bits",   32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b110, 32'hFFF0_0FFF, 1'b0);
    add_vec("xor_bits",  32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b111, 32'hFF00_0FF0, 1'b0);
    add_vec("add_wrap",  32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b0);
    add_vec("sub_wrap",  32'd3, 32'd20, 3'b001, 32'hFFFF_FFEF, 1'b0);
    add_vec("mul_wrap",  32'h0001_0000, 32'h0001_0000, 3'b010, 32'd0, 1'b0);
    add_vec("div_by_0",  32'd20, 32'd0, 3'b011, 32'hFFFF_FFFF, 1'b1);
    add_vec("mod_by_0",  32'd20, 32'd0, 3'b100, 32'd20, 1'b1);
    add_vec("add_after", 32'd20, 32'd0, 3'b000, 32'd20, 1'b0);
    add_vec("and_zero",  32'hAAAA_AAAA, 32'h5555_5555, 3'b101, 32'd0, 1'b0);
    add_vec("div_exact", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'd1, 1'b0);

    // Reset held for two edges with live operands.
    drive_edge(32'd20, 32'd3, 3'b000, 1'b0);
    check_out("reset_edge1", '0, 1'b1, 1'b0);
    drive_edge(32'd20, 32'd3, 3'b000, 1'b0);
    check_out("reset_edge2", '0, 1'b1, 1'b0);

    // Directed table, back to back: each result reflects the previous edge's inputs.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_edge(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
      check_out(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].dz);
    end

    // Random stream against the model, with an input-glitch hold check and a mid-stream reset.
    prev_r = result; prev_z = zero; prev_dz = div_zero;
    for (int i = 0; i < 300; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? '0 :
            (($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 40)) : W'($urandom));
      rop = 3'($urandom_range(0, 7));

      if (i % 10 == 3) begin
        a = ~ra; b = ~rb; op = ~rop;
        #2;
        check_out("hold_between_edges", prev_r, prev_z, prev_dz);
      end

      if (i == 150) begin
        drive_edge(ra, rb, rop, 1'b0);
        check_out("reset_midstream", '0, 1'b1, 1'b0);
      end else begin
        drive_edge(ra, rb, rop, 1'b1);
        ref_model(ra, rb, rop, exp_r, exp_dz);
        check_out((i == 151) ? "resume_after_reset" : "random", exp_r, (exp_r == '0), exp_dz);
      end
      prev_r = result; prev_z = zero; prev_dz = div_zero;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
